eth_tx_arbiter: RTL

// - Shares the single Ethernet TX frame builder between N_REQ frame sources (ARP, ICMP, DHCP, UDP data).
// - Round-robin grant, held for a whole frame, then an enforced inter-frame gap.
// - Until the board IP is configured (ip_ready low), only sources in PRE_IP_MASK (DHCP) are served.
// - The granted source index selects which source's header fields the builder reads, alongside the

---
 rtl/eth_tx_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// Round-robin arbiter sharing the Ethernet TX frame builder between N_REQ sources.
// Optional BUSY watchdog is built when ETH_TX_ARB_WATCHDOG_EN is defined.
module eth_tx_arbiter #(
  parameter int unsigned       N_REQ       = 4,
  parameter int unsigned       SEL_W       = 2,
  parameter int unsigned       IFG_CYCLES  = 12,
  parameter logic [N_REQ-1:0]  PRE_IP_MASK = 4'b0100,
  parameter int unsigned       WDOG_CYCLES = 65535,
  parameter int unsigned       WDOG_W      = 16
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [N_REQ-1:0] req,
  input  logic             ip_ready,
  input  logic             tx_done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] tx_sel,
  output logic             tx_start,
  output logic             busy,
  output logic             tx_abort,
  output logic             wdog_err
);

  localparam int unsigned GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  if (N_REQ < 2 || N_REQ > 8 || (1 << SEL_W) < N_REQ) begin : g_bad_req_cfg
    $error("eth_tx_arbiter: N_REQ must be 2..8 and fit in SEL_W");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > (2 ** WDOG_W) - 1) begin : g_bad_wdog_cfg
    $error("eth_tx_arbiter: WDOG_CYCLES must fit in WDOG_W bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   tx_sel_q, tx_sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;
  logic [N_REQ-1:0]   eligible;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic [SEL_W-1:0]   cand;
  logic               frame_end;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [WDOG_W-1:0]  wdog_q, wdog_d;
  logic               tx_abort_q, tx_abort_d;
  logic               wdog_err_q, wdog_err_d;
`endif

  always_comb begin
    eligible   = req & (ip_ready ? {N_REQ{1'b1}} : PRE_IP_MASK);
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = SEL_W'((32'(rr_q) + i) % N_REQ);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    tx_sel_d   = tx_sel_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    tx_start_d = 1'b0;
    frame_end  = 1'b0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
    wdog_d     = wdog_q;
    tx_abort_d = 1'b0;
    wdog_err_d = wdog_err_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d    = N_REQ'(1) << pick_idx;
          tx_sel_d   = pick_idx;
          tx_start_d = 1'b1;
          state_d    = S_BUSY;
`ifdef ETH_TX_ARB_WATCHDOG_EN
          wdog_d     = '0;
`endif
        end
      end
      S_BUSY: begin
        // tx_done coinciding with the tx_start cycle belongs to no accepted frame yet
        if (tx_done && !tx_start_q) begin
          frame_end = 1'b1;
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          frame_end  = 1'b1;
          tx_abort_d = 1'b1;
          wdog_err_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Normal completion and watchdog abort share the release/gap path
    if (frame_end) begin
      grant_d = '0;
      rr_d    = SEL_W'((32'(tx_sel_q) + 1) % N_REQ);
      if (IFG_CYCLES == 0) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_W'(IFG_CYCLES - 1);
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      tx_sel_q   <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      tx_sel_q   <= tx_sel_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wdog_q     <= '0;
      tx_abort_q <= 1'b0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_q     <= wdog_d;
      tx_abort_q <= tx_abort_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign tx_abort = tx_abort_q;
  assign wdog_err = wdog_err_q;
`else
  assign tx_abort = 1'b0;
  assign wdog_err = 1'b0;
`endif

  assign grant    = grant_q;
  assign tx_sel   = tx_sel_q;
  assign tx_start = tx_start_q;
  assign busy     = busy_q;

endmodule
